// File: rtl/tt_input_pkg.sv
// rtl/tt_input_pkg.sv - shared defaults and helpers for the switch debounce reader
package tt_input_pkg;

  localparam int DB_CYCLES_DEF   = 1000;
  localparam int LONG_CYCLES_DEF = 50000;
  localparam int EVT_CNT_W       = 8;

  function automatic logic [EVT_CNT_W-1:0] popcount(input logic [7:0] v);
    logic [EVT_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {{(EVT_CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one channel: synchroniser, debounce counter, edge and long-press pulses
// Long-press hold counter is built only when LONG_PRESS_EN is defined.
module debounce_ch
  import tt_input_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2 || DB_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_param
    $error("debounce_ch: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // The raw pin goes straight into the first flop; the level flips only on the
  // edge where the differing sample has been seen DB_CYCLES times in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold;

  // Saturating at HOLD_MAX is what keeps the pulse from repeating during one press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (!level) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold       <= hold + 1'b1;
        long_pulse <= (hold == HOLD_LAST);
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce_reader.sv
// rtl/switch_debounce_reader.sv - N-channel switch reader: debounced levels, edge pulses, rise counter
// Optional long-press detection per channel under LONG_PRESS_EN.
module switch_debounce_reader
  import tt_input_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      sw_in,
  output logic [N_CH-1:0]      sw_level,
  output logic [N_CH-1:0]      rise_pulse,
  output logic [N_CH-1:0]      fall_pulse,
  output logic                 any_event,
  output logic [EVT_CNT_W-1:0] event_cnt,
  output logic [N_CH-1:0]      long_pulse
);

  logic [7:0] rise_wide;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw_in[i]),
      .level     (sw_level[i]),
      .rise      (rise_pulse[i]),
      .fall      (fall_pulse[i]),
      .long_pulse(long_pulse[i])
    );
  end

  assign rise_wide = 8'(rise_pulse);
  assign any_event = |(rise_pulse | fall_pulse);

  // Counts the rises visible this cycle, so the total lands one cycle after the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt <= '0;
    end else begin
      event_cnt <= event_cnt + popcount(rise_wide);
    end
  end

endmodule

// File: tb/tb_switch_debounce_reader.sv
// tb/tb_switch_debounce_reader.sv - self-checking bench for switch_debounce_reader (honours LONG_PRESS_EN)
module tb_switch_debounce_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw_in;
  logic [7:0] sw_level, rise_pulse, fall_pulse, long_pulse;
  logic       any_event;
  logic [7:0] event_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  switch_debounce_reader #(
    .N_CH(8), .SYNC_STAGES(2), .DB_CYCLES(4), .LONG_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .sw_level(sw_level),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_event(any_event),
    .event_cnt(event_cnt), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] lvl;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       any;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Rise and fall must never coincide on a channel.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if ((rise_pulse & fall_pulse) !== 8'h00) begin
        n_fail++;
        $display("FAIL rise_fall_excl: got %0h expected 0 at %0t", rise_pulse & fall_pulse, $time);
      end
    end
  end

  initial begin
    int hit;
    int long_hits;

    for (int k = 0; k < 15; k++) begin
      tbl[k] = '{sw: 8'h01, lvl: 8'h01, rise: 8'h00, fall: 8'h00, any: 1'b0, cnt: 8'd9};
    end
    for (int k = 0; k < 5; k++) begin
      tbl[k].lvl = 8'h00;
      tbl[k].cnt = 8'd8;
    end
    tbl[5] = '{sw: 8'h01, lvl: 8'h01, rise: 8'h01, fall: 8'h00, any: 1'b1, cnt: 8'd8};
    for (int k = 7; k < 10; k++) tbl[k].sw = 8'h03;

    // Test 1: inputs high through reset
    rst_n = 1'b0;
    sw_in = 8'hFF;
    step(); step();
    chk("rst_level", sw_level, 8'h00);
    chk("rst_rise", rise_pulse, 8'h00);
    chk("rst_fall", fall_pulse, 8'h00);
    chk("rst_any", any_event, 1'b0);
    chk("rst_cnt", event_cnt, 8'd0);
    chk("rst_long", long_pulse, 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i < 6) chk("t1_no_rise_early", rise_pulse, 8'h00);
    end
    chk("t1_rise", rise_pulse, 8'hFF);
    chk("t1_level", sw_level, 8'hFF);
    chk("t1_any", any_event, 1'b1);
    step();
    chk("t1_cnt", event_cnt, 8'd8);
    chk("t1_rise_one_cycle", rise_pulse, 8'h00);

    // Release everything: falls do not count
    sw_in = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 6) chk("fall_all", fall_pulse, 8'hFF);
    end
    chk("fall_level", sw_level, 8'h00);
    chk("fall_cnt", event_cnt, 8'd8);

    // Tests 2 and 3: single-channel press, then a 3-cycle glitch on ch1
    for (int k = 0; k < 15; k++) begin
      sw_in = tbl[k].sw;
      step();
      chk($sformatf("tbl%0d_level", k), sw_level, tbl[k].lvl);
      chk($sformatf("tbl%0d_rise", k), rise_pulse, tbl[k].rise);
      chk($sformatf("tbl%0d_fall", k), fall_pulse, tbl[k].fall);
      chk($sformatf("tbl%0d_any", k), any_event, tbl[k].any);
      chk($sformatf("tbl%0d_cnt", k), event_cnt, tbl[k].cnt);
    end

    // Test 4: 32 presses of all channels wrap the counter
    rst_n = 1'b0;
    sw_in = 8'h00;
    step();
    chk("t4_rst_cnt", event_cnt, 8'd0);
    rst_n = 1'b1;
    for (int p = 0; p < 32; p++) begin
      sw_in = 8'hFF;
      repeat (8) step();
      sw_in = 8'h00;
      repeat (8) step();
      if (p == 30) chk("t4_cnt_31", event_cnt, 8'd248);
    end
    chk("t4_cnt_wrap", event_cnt, 8'd0);
    chk("t4_level", sw_level, 8'h00);

    // Test 5: reset while ch0 is mid-count
    sw_in = 8'h80;
    repeat (8) step();
    chk("t5_pre_level", sw_level, 8'h80);
    chk("t5_pre_cnt", event_cnt, 8'd1);
    sw_in = 8'h81;
    repeat (4) step();
    chk("t5_mid_level", sw_level, 8'h80);
    rst_n = 1'b0;
    #1;
    chk("t5_async_level", sw_level, 8'h00);
    chk("t5_async_cnt", event_cnt, 8'd0);
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i < 6) chk("t5_no_rise_early", rise_pulse, 8'h00);
    end
    chk("t5_rise", rise_pulse, 8'h81);
    chk("t5_level", sw_level, 8'h81);

    // Test 6: long press on ch2
    sw_in = 8'h04;
    hit = 0;
    for (int i = 1; i <= 20 && hit == 0; i++) begin
      step();
      if (rise_pulse[2]) hit = i;
    end
    chk("t6_rise_latency", hit, 6);
    hit = 0;
    long_hits = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (long_pulse != 8'h00) begin
        long_hits++;
        if (hit == 0) hit = i;
      end
    end
`ifdef LONG_PRESS_EN
    chk("t6_long_delay", hit, 10);
    chk("t6_long_once", long_hits, 1);
`else
    chk("t6_long_absent", long_hits, 0);
`endif
    chk("t6_level", sw_level, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, limit 200000");
    $fatal(1);
  end

endmodule
